// File: rtl/router_ovch_alloc_ctrl.sv
// Output-VC allocator and per-OVCH credit tracker for one router output port.
// Optional saturating grant counter enabled by defining OVCH_ALLOC_CNT_EN.
module router_ovch_alloc_ctrl #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_OVCH   = 2,
  parameter int MAX_CREDIT = 4,
  localparam int RW = (NUM_REQ  > 1) ? $clog2(NUM_REQ)  : 1,
  localparam int OW = (NUM_OVCH > 1) ? $clog2(NUM_OVCH) : 1,
  localparam int CW = $clog2(MAX_CREDIT + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQ-1:0]  head_req,
  output logic                grant_valid,
  output logic [RW-1:0]       grant_req,
  output logic [OW-1:0]       grant_ovch,
  input  logic                send_valid,
  input  logic [OW-1:0]       send_ovch,
  input  logic                send_tail,
  input  logic                cred_valid,
  input  logic [OW-1:0]       cred_ovch,
  output logic [NUM_OVCH-1:0] ovch_busy,
  output logic [NUM_OVCH-1:0] ovch_can_send,
  output logic                err_underflow,
  output logic                err_overflow
`ifdef OVCH_ALLOC_CNT_EN
  ,
  output logic [15:0]         grant_cnt
`endif
);

  logic [NUM_OVCH-1:0] busy;
  logic [RW-1:0]       owner [NUM_OVCH];
  logic [CW-1:0]       credit [NUM_OVCH];
  logic [RW-1:0]       rr_ptr;

  logic [NUM_REQ-1:0]  owns;
  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_OVCH-1:0] free;
  logic [NUM_OVCH-1:0] dec;
  logic [NUM_OVCH-1:0] inc;
  logic                win_found;
  logic [RW-1:0]       win_idx;
  logic                free_found;
  logic [OW-1:0]       free_idx;
  logic                alloc;

  // Ownership, eligibility, and per-OVCH send/credit strobes.
  always_comb begin
    owns = '0;
    for (int j = 0; j < NUM_OVCH; j++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (busy[j] && (owner[j] == RW'(i))) begin
          owns[i] = 1'b1;
        end else begin
          owns[i] = owns[i];
        end
      end
    end
    eligible = head_req & ~owns;
    for (int j = 0; j < NUM_OVCH; j++) begin
      free[j] = !busy[j] && (credit[j] == CW'(MAX_CREDIT));
      dec[j]  = send_valid && (send_ovch == OW'(j));
      inc[j]  = cred_valid && (cred_ovch == OW'(j));
      ovch_can_send[j] = busy[j] && (credit[j] != CW'(0));
    end
  end

  // Round-robin winner search starting at rr_ptr, and lowest free OVCH.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_idx   = RW'(idx);
      end else begin
        win_found = win_found;
      end
    end
    free_found = 1'b0;
    free_idx   = '0;
    for (int j = NUM_OVCH - 1; j >= 0; j--) begin
      if (free[j]) begin
        free_found = 1'b1;
        free_idx   = OW'(j);
      end else begin
        free_found = free_found;
      end
    end
    alloc = win_found && free_found;
  end

  assign ovch_busy = busy;

  // Ownership table, round-robin pointer and the registered grant pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy        <= '0;
      rr_ptr      <= '0;
      grant_valid <= 1'b0;
      grant_req   <= '0;
      grant_ovch  <= '0;
      for (int j = 0; j < NUM_OVCH; j++) begin
        owner[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_OVCH; j++) begin
        if (alloc && (free_idx == OW'(j))) begin
          busy[j]  <= 1'b1;
          owner[j] <= win_idx;
        end else if (dec[j] && send_tail) begin
          busy[j]  <= 1'b0;
          owner[j] <= '0;
        end else begin
          busy[j]  <= busy[j];
          owner[j] <= owner[j];
        end
      end
      grant_valid <= alloc;
      if (alloc) begin
        grant_req  <= win_idx;
        grant_ovch <= free_idx;
        rr_ptr     <= (win_idx == RW'(NUM_REQ - 1)) ? RW'(0) : win_idx + RW'(1);
      end else begin
        grant_req  <= grant_req;
        grant_ovch <= grant_ovch;
        rr_ptr     <= rr_ptr;
      end
    end
  end

  // Credit counters with sticky under/overflow detection; a send and a
  // return on the same OVCH cancel out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
      for (int j = 0; j < NUM_OVCH; j++) begin
        credit[j] <= CW'(MAX_CREDIT);
      end
    end else begin
      for (int j = 0; j < NUM_OVCH; j++) begin
        if (dec[j] && inc[j]) begin
          credit[j] <= credit[j];
        end else if (dec[j]) begin
          if (!busy[j] || (credit[j] == CW'(0))) begin
            err_underflow <= 1'b1;
          end else begin
            credit[j] <= credit[j] - CW'(1);
          end
        end else if (inc[j]) begin
          if (credit[j] == CW'(MAX_CREDIT)) begin
            err_overflow <= 1'b1;
          end else begin
            credit[j] <= credit[j] + CW'(1);
          end
        end else begin
          credit[j] <= credit[j];
        end
      end
    end
  end

`ifdef OVCH_ALLOC_CNT_EN
  // Saturating count of issued grants.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_cnt <= 16'h0000;
    end else if (alloc && (grant_cnt != 16'hFFFF)) begin
      grant_cnt <= grant_cnt + 16'h0001;
    end else begin
      grant_cnt <= grant_cnt;
    end
  end
`endif

endmodule

// File: doc/router_ovch_alloc_ctrl.md
Name: router_ovch_alloc_ctrl

Overview:
- Output-virtual-channel (OVCH) allocator and credit tracker for one router output port in the router_wrap slice.
- Grants free OVCHs to input-side requesters holding head flits, using round-robin between requesters.
- Tracks ownership of each OVCH until its tail flit, and keeps a downstream credit count per OVCH.
- Drives the per-OVCH send-enable vector used by the switch stage and the ff_OVCH state bits.

Parameters:
- NUM_REQ, 4, number of requesting input VCs; indices 0..NUM_REQ-1.
- NUM_OVCH, 2, number of output virtual channels; indices 0..NUM_OVCH-1.
- MAX_CREDIT, 4, downstream buffer depth per OVCH; the credit counter is $clog2(MAX_CREDIT+1) bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; all state is cleared while reset=0.
- head_req  input  NUM_REQ  bit i: requester i holds a head flit and needs an OVCH.
- grant_valid  output  1  registered one-cycle allocation pulse.
- grant_req  output  $clog2(NUM_REQ)  winning requester index, valid when grant_valid=1.
- grant_ovch  output  $clog2(NUM_OVCH)  allocated OVCH index, valid when grant_valid=1.
- send_valid  input  1  switch forwards one flit on an OVCH this cycle.
- send_ovch  input  $clog2(NUM_OVCH)  OVCH of that flit.
- send_tail  input  1  that flit is the tail flit.
- cred_valid  input  1  downstream returns one credit.
- cred_ovch  input  $clog2(NUM_OVCH)  OVCH of the returned credit.
- ovch_busy  output  NUM_OVCH  OVCH is currently allocated.
- ovch_can_send  output  NUM_OVCH  busy AND credit>0; derived combinationally from registers.
- err_underflow  output  1  sticky: a send occurred at credit 0, or on an unallocated OVCH.
- err_overflow  output  1  sticky: a credit return would exceed MAX_CREDIT.

Behaviour:
- Reset values (reset=0, asynchronous):
  - busy=0, owner table cleared, every credit=MAX_CREDIT, rr_ptr=0.
  - grant_valid=0, grant_req=0, grant_ovch=0, both error flags 0.
  - A reset mid-packet discards all ownership; no grant is issued in the first cycle after release.
- Eligibility:
  - Requester i is eligible when head_req[i]=1 and it owns no OVCH.
  - OVCH j is free when busy[j]=0 and credit[j]==MAX_CREDIT. An OVCH is never reallocated while credits are outstanding.
- Allocation, at most one per cycle:
  - If any requester is eligible and any OVCH is free, the winner is the first eligible requester searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - The allocated OVCH is the lowest-index free OVCH.
  - At that edge: busy[j]=1, owner[j]=winner, rr_ptr=(winner+1) mod NUM_REQ, grant_valid=1 for exactly one cycle.
  - Latency: head_req sampled at edge k gives grant_valid high between edges k and k+1.
  - head_req held after a grant is ignored while the requester owns an OVCH.
  - With no free OVCH, nothing changes, rr_ptr holds, and requests keep waiting. No starvation: rr_ptr rotates only on a grant.
- Send:
  - send_valid decrements credit[send_ovch].
  - At credit 0, or with busy=0, err_underflow is set and credit stays at 0.
  - send_tail=1 clears busy and owner at that edge. The OVCH is eligible again at the next edge, once all credits are back.
- Credit return:
  - cred_valid increments credit[cred_ovch].
  - At MAX_CREDIT, err_overflow is set and the credit saturates.
- Simultaneous events:
  - Send and credit return on the same OVCH in one cycle leave the credit unchanged and raise no error.
  - A tail send and an allocation in the same cycle never target the same OVCH.
- Error flags clear only on reset.

Optional Feature:
- Macro: OVCH_ALLOC_CNT_EN.
- Defined: adds output grant_cnt[15:0], a saturating count of grant_valid pulses. Reset value 0; it stops at 16'hFFFF.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, then head_req=4'b0001 → next cycle grant_valid=1, grant_req=0, grant_ovch=0, ovch_busy=2'b01; rr_ptr=1.
- head_req=4'b1111 held from reset with no sends → grants go to req 0 then req 1 (OVCH 0 then 1), then no grant; ovch_busy=2'b11.
- After that, send 4 flits on OVCH 0 (tail on the 4th) → ovch_can_send[0] drops after the 4th flit and busy[0] clears. No regrant until 4 credits return; the regrant then goes to req 2, per the round-robin order.
- Credit return and send on OVCH 1 in the same cycle at credit=2 → credit stays 2, no error flags.
- Send on OVCH 0 at credit 0 → err_underflow=1 and stays 1; credit return at credit 4 → err_overflow=1.
- Assert reset mid-packet with busy=2'b11 and credits at 1 → all outputs go to reset values immediately, credits read 4, and no spurious grant occurs.
